// File: rtl/scs8hd_cell_test_seq.sv
// Truth-table sequencer for one 2-input library cell: walks every {B,A} vector, lets the
// cell settle, samples Y against the expected table and counts mismatches.
module scs8hd_cell_test_seq #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 1,
    parameter logic [3:0]  EXP_TABLE  = 4'b0111,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_a_drv,
    output logic             o_b_drv,
    input  logic             i_y_obs,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fail,
    output logic [1:0]       o_first_fail_idx,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [7:0]       r_loop;
    logic [7:0]       r_settle_cnt;
    logic [1:0]       r_drv;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [1:0]       r_first_fail_idx;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_mismatch;
    logic             w_last_vector;
    logic [1:0]       w_next_idx;

    // Case-inequality so that an X or Z on the observed output is reported as a failure
    assign w_mismatch    = (i_y_obs !== EXP_TABLE[r_idx]);
    assign w_last_vector = (r_idx == 2'd3) && (r_loop == LOOP_LAST);
    assign w_next_idx    = r_idx + 2'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_idx            <= 2'd0;
            r_loop           <= 8'd0;
            r_settle_cnt     <= 8'd0;
            r_drv            <= 2'b00;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_fail           <= 1'b0;
            r_first_fail_idx <= 2'd0;
            r_err_cnt        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_drv <= 2'b00;
                    if (i_start) begin
                        r_state          <= SETTLE;
                        r_idx            <= 2'd0;
                        r_loop           <= 8'd0;
                        r_settle_cnt     <= 8'd0;
                        r_busy           <= 1'b1;
                        r_fail           <= 1'b0;
                        r_first_fail_idx <= 2'd0;
                        r_err_cnt        <= '0;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= 8'd0;
                        r_state      <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (!r_fail) begin
                            r_fail           <= 1'b1;
                            r_first_fail_idx <= r_idx;
                        end
                    end
                    if (w_last_vector) begin
                        r_state <= FINISH;
                        r_drv   <= 2'b00;
                        r_done  <= 1'b1;
                    end else begin
                        // Vector 3 wraps back to 0 and opens the next pass
                        r_idx   <= w_next_idx;
                        r_drv   <= w_next_idx;
                        r_state <= SETTLE;
                        if (r_idx == 2'd3) begin
                            r_loop <= r_loop + 8'd1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_drv   <= 2'b00;
                end
            endcase
        end
    end

    assign o_a_drv          = r_drv[0];
    assign o_b_drv          = r_drv[1];
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_fail           = r_fail;
    assign o_first_fail_idx = r_first_fail_idx;
    assign o_err_cnt        = r_err_cnt;

endmodule
